// File: rtl/axi4lite_master_bridge.sv
// Single-outstanding AXI4-lite initiator: converts a simple valid/ready CPU request
// into one AXI4-lite read or write and returns a one-cycle completion pulse.
module axi4lite_master_bridge #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter logic [2:0] PROT_VALUE = 3'b000
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDR_WIDTH-1:0]     req_addr,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    output logic                      rsp_valid,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic                      AWVALID,
    input  logic                      AWREADY,
    output logic [ADDR_WIDTH-1:0]     AWADDR,
    output logic [2:0]                AWPROT,
    output logic                      WVALID,
    input  logic                      WREADY,
    output logic [DATA_WIDTH-1:0]     WDATA,
    output logic [DATA_WIDTH/8-1:0]   WSTRB,
    input  logic                      BVALID,
    output logic                      BREADY,
    input  logic [1:0]                BRESP,
    output logic                      ARVALID,
    input  logic                      ARREADY,
    output logic [ADDR_WIDTH-1:0]     ARADDR,
    output logic [2:0]                ARPROT,
    input  logic                      RVALID,
    output logic                      RREADY,
    input  logic [DATA_WIDTH-1:0]     RDATA,
    input  logic [1:0]                RRESP
);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP} state_t;

    state_t state_reg;
    logic   aw_done_reg;
    logic   w_done_reg;
    logic   aw_hs;
    logic   w_hs;

    assign req_ready = (state_reg == IDLE);
    assign AWPROT    = PROT_VALUE;
    assign ARPROT    = PROT_VALUE;
    assign aw_hs     = AWVALID && AWREADY;
    assign w_hs      = WVALID && WREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg   <= IDLE;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            AWVALID     <= 1'b0;
            WVALID      <= 1'b0;
            ARVALID     <= 1'b0;
            BREADY      <= 1'b0;
            RREADY      <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            AWADDR      <= '0;
            ARADDR      <= '0;
            WDATA       <= '0;
            WSTRB       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        if (req_write) begin
                            AWADDR      <= req_addr;
                            WDATA       <= req_wdata;
                            WSTRB       <= req_wstrb;
                            AWVALID     <= 1'b1;
                            WVALID      <= 1'b1;
                            aw_done_reg <= 1'b0;
                            w_done_reg  <= 1'b0;
                            state_reg   <= WR_REQ;
                        end else begin
                            ARADDR    <= req_addr;
                            ARVALID   <= 1'b1;
                            state_reg <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    // AW and W retire independently; move on once both are done,
                    // counting a handshake landing in this very cycle.
                    if (aw_hs) begin
                        AWVALID     <= 1'b0;
                        aw_done_reg <= 1'b1;
                    end
                    if (w_hs) begin
                        WVALID     <= 1'b0;
                        w_done_reg <= 1'b1;
                    end
                    if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
                        BREADY    <= 1'b1;
                        state_reg <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BVALID) begin
                        BREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= (BRESP != 2'b00);
                        rsp_rdata <= '0;
                        state_reg <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (ARREADY) begin
                        ARVALID   <= 1'b0;
                        RREADY    <= 1'b1;
                        state_reg <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (RVALID) begin
                        RREADY    <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= (RRESP != 2'b00);
                        rsp_rdata <= RDATA;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4lite_master_bridge.sv
// Bench for axi4lite_master_bridge: a delay-programmable AXI4-lite slave model plus
// a queue of expected completions popped whenever rsp_valid pulses.
module tb_axi4lite_master_bridge;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
    logic [3:0]  WSTRB;
    logic [2:0]  AWPROT, ARPROT;
    logic [1:0]  BRESP, RRESP;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t expq[$];
    int   tests_run = 0;
    int   failed = 0;

    int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    logic        force_b = 1'b0;
    logic [31:0] rdata_v = 32'h0;
    logic [1:0]  bresp_v = 2'b00, rresp_v = 2'b00;

    assign RDATA = rdata_v;
    assign BRESP = bresp_v;
    assign RRESP = rresp_v;

    always #5 ACLK = ~ACLK;

    axi4lite_master_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .PROT_VALUE(3'b000)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP)
    );

    // Slave model: each READY/VALID rises after the programmed number of waiting cycles.
    always @(negedge ACLK) begin
        if (AWVALID) begin AWREADY = (aw_cnt == aw_delay); aw_cnt++; end
        else begin AWREADY = 1'b0; aw_cnt = 0; end
        if (WVALID) begin WREADY = (w_cnt == w_delay); w_cnt++; end
        else begin WREADY = 1'b0; w_cnt = 0; end
        if (ARVALID) begin ARREADY = (ar_cnt == ar_delay); ar_cnt++; end
        else begin ARREADY = 1'b0; ar_cnt = 0; end
        if (BREADY) begin BVALID = (b_cnt == b_delay); b_cnt++; end
        else begin BVALID = force_b; b_cnt = 0; end
        if (RREADY) begin RVALID = (r_cnt == r_delay); r_cnt++; end
        else begin RVALID = 1'b0; r_cnt = 0; end
    end

    // Call on a negedge with the bridge idle; returns just after the accepting edge.
    task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic e, input logic [31:0] rd);
        exp_t x;
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wstrb = s;
        x.err = e; x.rdata = rd;
        expq.push_back(x);
        @(posedge ACLK);
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge ACLK);
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        ARESET = 1'b1; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wstrb = '0;
        repeat (3) @(negedge ACLK);
        ARESET = 1'b0;
        @(negedge ACLK);
        tests_run++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_err} !== 7'b0) begin
            failed++;
            $display("FAIL reset_ctrl got=%b want=0000000",
                     {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_err});
        end
        tests_run++;
        if ({rsp_rdata, AWADDR, ARADDR, WDATA, WSTRB, AWPROT, ARPROT} !== '0) begin
            failed++;
            $display("FAIL reset_data rdata=%h awaddr=%h araddr=%h wdata=%h wstrb=%h want all 0",
                     rsp_rdata, AWADDR, ARADDR, WDATA, WSTRB);
        end
        tests_run++;
        if (req_ready !== 1'b1) begin
            failed++;
            $display("FAIL reset_req_ready got=%b want=1", req_ready);
        end
    endtask

    task automatic test_write_fast;
        exp_t x;
        bresp_v = 2'b00;
        @(negedge ACLK);
        drive_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        @(negedge ACLK);
        tests_run++;
        if ({AWVALID, WVALID, AWADDR, WDATA, WSTRB} !== {2'b11, 32'h10, 32'hDEAD_BEEF, 4'hF}) begin
            failed++;
            $display("FAIL wr_fast_n1 awv=%b wv=%b awaddr=%h wdata=%h wstrb=%h want 1 1 10 deadbeef f",
                     AWVALID, WVALID, AWADDR, WDATA, WSTRB);
        end
        @(negedge ACLK);
        tests_run++;
        if ({AWVALID, WVALID, BREADY, rsp_valid} !== 4'b0010) begin
            failed++;
            $display("FAIL wr_fast_n2 awv/wv/bready/rsp=%b want 0010",
                     {AWVALID, WVALID, BREADY, rsp_valid});
        end
        @(negedge ACLK);
        tests_run++;
        if ({rsp_valid, BREADY} !== 2'b10) begin
            failed++;
            $display("FAIL wr_fast_n3 rsp_valid/bready=%b want 10", {rsp_valid, BREADY});
        end
        x = expq.pop_front();
        tests_run++;
        if ({rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL wr_fast_rsp err=%b rdata=%h want err=%b rdata=%h",
                     rsp_err, rsp_rdata, x.err, x.rdata);
        end
        @(negedge ACLK);
        tests_run++;
        if (rsp_valid !== 1'b0) begin
            failed++;
            $display("FAIL wr_fast_pulse rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_write_aw_delay;
        exp_t x;
        bit   seen;
        int   bad = 0;
        aw_delay = 3;
        @(negedge ACLK);
        drive_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            @(negedge ACLK);
            if (AWVALID !== 1'b1 || AWADDR !== 32'h10 || BREADY !== 1'b0 ||
                WVALID !== (k == 0)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL wr_awdly_hold bad_cycles=%0d want 0", bad);
        end
        @(negedge ACLK);
        tests_run++;
        if ({AWVALID, WVALID, BREADY} !== 3'b001) begin
            failed++;
            $display("FAIL wr_awdly_bready awv/wv/bready=%b want 001", {AWVALID, WVALID, BREADY});
        end
        wait_rsp(seen);
        x = expq.pop_front();
        tests_run++;
        if (!seen || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL wr_awdly_rsp seen=%b err=%b rdata=%h want 1 %b %h",
                     seen, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        aw_delay = 0;
    endtask

    task automatic test_read_wait;
        exp_t x;
        int   rready_cycles = 0;
        int   pulses = 0;
        bit   seen = 1'b0;
        r_delay = 2; rdata_v = 32'h1234_5678; rresp_v = 2'b00;
        @(negedge ACLK);
        drive_req(1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 32'h1234_5678);
        @(negedge ACLK);
        tests_run++;
        if ({ARVALID, ARADDR, AWVALID, WVALID} !== {1'b1, 32'h20, 2'b00}) begin
            failed++;
            $display("FAIL rd_arvalid arv=%b araddr=%h awv=%b wv=%b want 1 20 0 0",
                     ARVALID, ARADDR, AWVALID, WVALID);
        end
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (RREADY === 1'b1) rready_cycles++;
            if (rsp_valid === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (rready_cycles != 3) begin
            failed++;
            $display("FAIL rd_rready_len got=%0d want 3", rready_cycles);
        end
        x = expq.pop_front();
        tests_run++;
        if (!seen || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL rd_rsp seen=%b err=%b rdata=%h want 1 %b %h",
                     seen, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            if (rsp_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (pulses != 0 || rsp_rdata !== 32'h1234_5678) begin
            failed++;
            $display("FAIL rd_single_pulse extra=%0d held_rdata=%h want 0 12345678",
                     pulses, rsp_rdata);
        end
        r_delay = 0;
    endtask

    task automatic test_errors;
        exp_t x;
        bit   seen;
        rresp_v = 2'b10; rdata_v = 32'hCAFE_0001;
        @(negedge ACLK);
        drive_req(1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'hCAFE_0001);
        wait_rsp(seen);
        x = expq.pop_front();
        tests_run++;
        if (!seen || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL rd_slverr seen=%b err=%b rdata=%h want 1 %b %h",
                     seen, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        rresp_v = 2'b00; bresp_v = 2'b11; b_delay = 1; w_delay = 2;
        @(negedge ACLK);
        drive_req(1'b1, 32'h0000_0044, 32'h5555_AAAA, 4'h3, 1'b1, 32'h0);
        wait_rsp(seen);
        x = expq.pop_front();
        tests_run++;
        if (!seen || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL wr_decerr seen=%b err=%b rdata=%h want 1 %b %h",
                     seen, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        bresp_v = 2'b00; b_delay = 0; w_delay = 0;
    endtask

    task automatic test_back_to_back;
        exp_t x;
        bit   seen;
        int   extra = 0;
        rdata_v = 32'hA5A5_0F0F; ar_delay = 1;
        @(negedge ACLK);
        drive_req(1'b1, 32'h0000_0080, 32'h0BAD_F00D, 4'hC, 1'b0, 32'h0);
        wait_rsp(seen);
        x = expq.pop_front();
        tests_run++;
        if (!seen || req_ready !== 1'b1 || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL b2b_wr_rsp seen=%b req_ready=%b err=%b rdata=%h want 1 1 %b %h",
                     seen, req_ready, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        drive_req(1'b0, 32'h0000_0084, 32'h0, 4'h0, 1'b0, 32'hA5A5_0F0F);
        @(negedge ACLK);
        tests_run++;
        if ({ARVALID, rsp_valid, req_ready} !== 3'b100) begin
            failed++;
            $display("FAIL b2b_rd_accept arv/rsp_valid/req_ready=%b want 100",
                     {ARVALID, rsp_valid, req_ready});
        end
        wait_rsp(seen);
        x = expq.pop_front();
        tests_run++;
        if (!seen || {rsp_err, rsp_rdata} !== {x.err, x.rdata}) begin
            failed++;
            $display("FAIL b2b_rd_rsp seen=%b err=%b rdata=%h want 1 %b %h",
                     seen, rsp_err, rsp_rdata, x.err, x.rdata);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            if (rsp_valid === 1'b1) extra++;
        end
        tests_run++;
        if (extra != 0 || expq.size() != 0) begin
            failed++;
            $display("FAIL b2b_no_dup extra=%0d pending=%0d want 0 0", extra, expq.size());
        end
        ar_delay = 0;
    endtask

    task automatic test_spurious;
        int bad = 0;
        force_b = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            if (BREADY !== 1'b0 || RREADY !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) bad++;
        end
        force_b = 1'b0;
        tests_run++;
        if (bad != 0) begin
            failed++;
            $display("FAIL spurious_bvalid bad_cycles=%0d want 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        bit seen = 1'b0;
        int pulses = 0;
        b_delay = 6;
        @(negedge ACLK);
        drive_req(1'b1, 32'h0000_00C0, 32'h1111_2222, 4'hF, 1'b0, 32'h0);
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge ACLK);
            if (BREADY === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            failed++;
            $display("FAIL rst_mid_reach_wr_resp bready_seen=%b want 1", seen);
        end
        #2 ARESET = 1'b1;
        void'(expq.pop_back());
        #1;
        tests_run++;
        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid} !== 6'b0 ||
            {AWADDR, WDATA, WSTRB} !== '0) begin
            failed++;
            $display("FAIL rst_mid_async ctrl=%b awaddr=%h wdata=%h want 000000 0 0",
                     {AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid}, AWADDR, WDATA);
        end
        @(negedge ACLK);
        ARESET = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ACLK);
            if (rsp_valid === 1'b1) pulses++;
        end
        tests_run++;
        if (req_ready !== 1'b1 || pulses != 0 || BREADY !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid_after req_ready=%b pulses=%0d bready=%b want 1 0 0",
                     req_ready, pulses, BREADY);
        end
        b_delay = 0;
    endtask

    initial begin
        test_reset();
        test_write_fast();
        test_write_aw_delay();
        test_read_wait();
        test_errors();
        test_back_to_back();
        test_spurious();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule

// File: doc/axi4lite_master_bridge.md
Name: axi4lite_master_bridge

Overview:
- Initiator end of the team's AXI4-lite interface: turns a simple single-request CPU bus into AXI4-lite read and write transactions on the master modport signals.
- Drives our generated register blocks, which are AXI4-lite slaves, from testbenches, debug bridges and small sequencers.
- One transaction outstanding at a time. AW and W are issued together and retire independently. Responses come back as a one-cycle pulse.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits.
DATA_WIDTH, 32, AXI data width in bits; 32 or 64 only.
PROT_VALUE, 3'b000, constant driven on AWPROT and ARPROT.

Ports:
ACLK  input  1  clock; everything is sampled on the rising edge.
ARESET  input  1  asynchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  bridge is idle and can take a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  byte address.
req_wdata  input  DATA_WIDTH  write data.
req_wstrb  input  DATA_WIDTH/8  write byte strobes.
rsp_valid  output  1  one-cycle completion pulse.
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
rsp_err  output  1  1 if BRESP or RRESP is not OKAY (2'b00).
AWVALID  output  1  write address valid.
AWREADY  input  1  write address ready.
AWADDR  output  ADDR_WIDTH  write address.
AWPROT  output  3  write protection attributes.
WVALID  output  1  write data valid.
WREADY  input  1  write data ready.
WDATA  output  DATA_WIDTH  write data.
WSTRB  output  DATA_WIDTH/8  write strobes.
BVALID  input  1  write response valid.
BREADY  output  1  write response ready.
BRESP  input  2  write response code.
ARVALID  output  1  read address valid.
ARREADY  input  1  read address ready.
ARADDR  output  ADDR_WIDTH  read address.
ARPROT  output  3  read protection attributes.
RVALID  input  1  read data valid.
RREADY  output  1  read data ready.
RDATA  input  DATA_WIDTH  read data.
RRESP  input  2  read response code.

Behaviour:
- Reset values, all registered:
  - AWVALID, WVALID, ARVALID, BREADY, RREADY, rsp_valid, rsp_err = 0.
  - rsp_rdata, AWADDR, ARADDR, WDATA, WSTRB = 0.
  - FSM in IDLE.
- req_ready = (state == IDLE), combinational from state. A request is accepted on req_valid && req_ready.
- Acceptance at edge N:
  - Address, data and strobes are captured.
  - A write asserts AWVALID and WVALID from cycle N+1. A read asserts ARVALID from cycle N+1.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP.
- IDLE: a write goes to WR_REQ; a read goes to RD_REQ.
- WR_REQ:
  - AWVALID drops the cycle after AWVALID&&AWREADY.
  - WVALID drops the cycle after WVALID&&WREADY.
  - The two handshakes may fall in the same cycle or in either order.
  - Once both have completed (tracked with aw_done/w_done flags), go to WR_RESP and assert BREADY.
  - A VALID is never withdrawn before its handshake. AWADDR, WDATA and WSTRB stay stable while their VALID is high.
- WR_RESP:
  - BREADY stays high until BVALID.
  - On BVALID&&BREADY: BREADY drops, rsp_valid pulses on the next cycle, rsp_err = (BRESP != 0), rsp_rdata = 0, then return to IDLE.
- RD_REQ: ARVALID stays high until ARREADY. On the handshake, ARVALID drops, RREADY asserts, and the FSM goes to RD_RESP.
- RD_RESP: on RVALID&&RREADY, RREADY drops, rsp_rdata = RDATA, rsp_err = (RRESP != 0), rsp_valid pulses next cycle, then return to IDLE.
- Response timing:
  - rsp_valid is high for exactly one cycle, with no backpressure.
  - rsp_rdata and rsp_err hold their values until the next completion.
- req_ready is 1 in the cycle rsp_valid pulses, so back-to-back requests are allowed.
- Minimum latency with an always-ready slave:
  - Write: accept N, AW/W handshake N+1, B handshake N+2, rsp_valid N+3.
  - Read: accept N, AR handshake N+1, R handshake N+2, rsp_valid N+3.
- BVALID or RVALID arriving in a state that does not expect it is ignored; READY stays 0.
- ARESET mid-transaction:
  - All outputs return to reset values immediately and asynchronously.
  - The FSM goes to IDLE and the pending transaction is dropped with no rsp_valid.
- AWPROT and ARPROT are driven as PROT_VALUE constantly.
- Reads and writes never overlap.

Test Plan:
- Write 0x0000_0010 / 0xDEAD_BEEF / strb 0xF to an always-ready slave, BRESP=0 -> AWVALID and WVALID high at N+1, BREADY at N+2, rsp_valid at N+3, rsp_err=0.
- Same write with AWREADY delayed 3 cycles and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds for 4 cycles with AWADDR stable, BREADY only after both handshakes.
- Read 0x0000_0020, slave returns RDATA=0x1234_5678 after 2 wait cycles on R -> RREADY high 3 cycles, rsp_rdata=0x1234_5678, rsp_err=0, one rsp_valid pulse.
- Read with RRESP=2'b10 -> rsp_err=1; a following write with BRESP=2'b11 -> rsp_err=1 and rsp_rdata=0.
- Read issued in the same cycle rsp_valid pulses for a previous write -> accepted, ARVALID next cycle, no lost or duplicated response.
- ARESET asserted while in WR_RESP -> all VALID/READY signals 0 immediately, req_ready=1 after release, no rsp_valid for the aborted write.
